// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder responder: operand/sum widths and counter width.
package adder_pkg;

  localparam int ADDER_W   = 4;
  localparam int CNT_W_DEF = 16;

  typedef logic [ADDER_W-1:0] opnd_t;
  typedef logic [ADDER_W:0]   sum_t;

endpackage

// File: rtl/adder_rsp_unit_if.sv
// Driver/monitor handshake bundle: operand pairs in over valid/ready, sums out over valid/ready.
interface adder_rsp_unit_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s
  );

endinterface

// File: rtl/adder_rsp_fifo.sv
// Synchronous FIFO, DEPTH x W, 1-cycle write-to-read latency, registered count.
// Push while full and pop while empty are ignored; no bypass in either direction.
module adder_rsp_fifo #(
  parameter  int W     = 5,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/adder_rsp_unit.sv
// Adder responder: sums a+b into a result FIFO, 1-cycle in->out latency, in_ready drops when full.
// Optional carry statistic counter enabled by ADDER_RSP_CARRY_STAT_EN.
module adder_rsp_unit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  adder_rsp_unit_if.slave  bus,
  output logic [CNT_W-1:0] acc_cnt
`ifdef ADDER_RSP_CARRY_STAT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             rdy_en_q, rdy_en_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             push, pop;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;

  assign sum = {1'b0, bus.a} + {1'b0, bus.b};

  // rdy_en_q holds in_ready low through reset and for the release edge itself.
  assign bus.in_ready  = rdy_en_q && !fifo_full;
  assign bus.out_valid = (fifo_cnt != '0);
  assign bus.s         = fifo_empty ? '0 : head;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  adder_rsp_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (sum),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    rdy_en_d  = 1'b1;
    acc_cnt_d = acc_cnt_q;
    if (push) acc_cnt_d = acc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;

`ifdef ADDER_RSP_CARRY_STAT_EN
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (push && sum[WIDTH]) carry_cnt_d = carry_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) carry_cnt_q <= '0;
    else     carry_cnt_q <= carry_cnt_d;
  end

  assign carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_adder_rsp_unit.sv
// Bench for adder_rsp_unit: directed scenarios plus random traffic against a queue-based reference.
module tb_adder_rsp_unit;
  import adder_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] acc_cnt;
`ifdef ADDER_RSP_CARRY_STAT_EN
  logic [CW-1:0] carry_cnt;
`endif

  adder_rsp_unit_if #(.WIDTH(ADDER_W)) bus ();

  adder_rsp_unit #(
    .WIDTH (ADDER_W),
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .acc_cnt   (acc_cnt)
`ifdef ADDER_RSP_CARRY_STAT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  sum_t        exp_q[$];
  int unsigned acc_exp   = 0;
  int unsigned carry_exp = 0;
  logic        rst_edge  = 1'b1;
  logic        take      = 1'b0;
  sum_t        take_sum  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Acceptance is decided by the levels just before the edge.
  always @(negedge clk) begin
    take     = bus.in_valid && bus.in_ready;
    take_sum = sum_t'(int'(bus.a) + int'(bus.b));
  end

  // Reference model: the queue holds every accepted, not-yet-consumed sum.
  always @(posedge clk) begin
    rst_edge = rst;
    if (rst) begin
      exp_q.delete();
      acc_exp   = 0;
      carry_exp = 0;
    end else if (take) begin
      exp_q.push_back(take_sum);
      acc_exp = (acc_exp + 1) % 65536;
      if (int'(take_sum) >= (1 << ADDER_W)) carry_exp = (carry_exp + 1) % 65536;
    end
  end

  // Monitor: compare DUT outputs against the model and consume on handshake.
  always @(negedge clk) begin
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(bus.in_ready), 64'(!rst_edge && exp_q.size() < DEPTH));
    check("acc_cnt", 64'(acc_cnt), 64'(acc_exp));
`ifdef ADDER_RSP_CARRY_STAT_EN
    check("carry_cnt", 64'(carry_cnt), 64'(carry_exp));
`endif
    if (exp_q.size() > 0) check("s", 64'(bus.s), 64'(exp_q[0]));
    else                  check("s_idle", 64'(bus.s), 64'd0);
    if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic iv, input int ia, input int ib, input logic ordy);
    bus.in_valid  = iv;
    bus.a         = opnd_t'(ia);
    bus.b         = opnd_t'(ib);
    bus.out_ready = ordy;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    drive(1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold_rdy", 64'(bus.in_ready), 64'd0);
    tick(1);
    @(negedge clk);
    check("rst_rel_rdy", 64'(bus.in_ready), 64'd1);
    check("rst_acc", 64'(acc_cnt), 64'd0);
    check("rst_s", 64'(bus.s), 64'd0);

    // Single transaction with carry out.
    tick(1);
    drive(1'b1, 15, 1, 1'b1);
    tick(1);
    drive(1'b0, 0, 0, 1'b1);
    @(negedge clk);
    check("single_vld", 64'(bus.out_valid), 64'd1);
    check("single_s", 64'(bus.s), 64'h10);
    check("single_acc", 64'(acc_cnt), 64'd1);
    tick(1);

    // Fill to full with the consumer stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2 * i + 1, 2 * i + 2, 1'b0);
      tick(1);
    end
    drive(1'b1, 10, 11, 1'b0);
    @(negedge clk);
    check("fill_full", 64'(bus.in_ready), 64'd0);
    check("fill_head", 64'(bus.s), 64'd3);
    tick(2);
    drive(1'b0, 0, 0, 1'b1);
    tick(5);
    @(negedge clk);
    check("fill_acc", 64'(acc_cnt), 64'd5);
    check("drain_vld", 64'(bus.out_valid), 64'd0);

    // Push and pop in the same cycle at count=2.
    tick(1);
    drive(1'b1, 1, 1, 1'b0);
    tick(1);
    drive(1'b1, 2, 2, 1'b0);
    tick(1);
    drive(1'b1, 9, 9, 1'b1);
    tick(1);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("conc_head", 64'(bus.s), 64'd4);
    tick(1);
    drive(1'b0, 0, 0, 1'b1);
    tick(3);

    // Reset with entries queued discards them.
    drive(1'b1, 3, 3, 1'b0);
    tick(3);
    drive(1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check("mid_rst_acc", 64'(acc_cnt), 64'd0);
    check("mid_rst_s", 64'(bus.s), 64'd0);
    tick(1);
    drive(1'b1, 2, 2, 1'b0);
    tick(1);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("post_rst_s", 64'(bus.s), 64'd4);
    tick(1);
    drive(1'b0, 0, 0, 1'b1);
    tick(2);

    // Carry statistic from a clean reset.
    pulse_reset();
    drive(1'b1, 8, 8, 1'b1);
    tick(1);
    drive(1'b1, 1, 1, 1'b1);
    tick(1);
    drive(1'b1, 15, 15, 1'b1);
    tick(1);
    drive(1'b0, 0, 0, 1'b1);
    @(negedge clk);
    check("carry_acc", 64'(acc_cnt), 64'd3);
`ifdef ADDER_RSP_CARRY_STAT_EN
    check("carry_cnt2", 64'(carry_cnt), 64'd2);
`endif
    tick(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b1);
    tick(8);
    @(negedge clk);
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
